// File: rtl/ram_port_master.sv
// Initiator for one synchronous RAM port: optional clear after reset,
// then a request stream in and a credit-limited read response stream out.
module ram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH = 4,
    parameter int INIT_EN = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  init_done
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic                  init_done_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW:0]           used;
    logic                  fire;
    logic                  push;
    logic                  pop;

    // Credits cover both buffered data and the read whose q is still due.
    assign used      = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign req_ready = init_done_q && (used < (CW+1)'(RSP_DEPTH));
    assign fire      = req_valid && req_ready;
    assign push      = inflight_q;
    assign pop       = rsp_valid && rsp_ready;
    assign init_done = init_done_q;
    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

    // Next state and RAM port drive; INIT writes are masked while in reset.
    always_comb begin
        state_d  = state_q;
        ram_we   = 1'b0;
        ram_addr = req_addr;
        ram_data = req_data;
        case (state_q)
            S_INIT: begin
                ram_we   = rst;
                ram_addr = init_cnt_q;
                ram_data = INIT_VALUE;
                if (init_cnt_q == '1) state_d = S_RUN;
            end
            default: begin
                ram_we = fire && req_we;
            end
        endcase
    end

    // FSM state, clear address counter and the registered done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= (INIT_EN != 0) ? S_INIT : S_RUN;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == S_RUN);
            if (state_q == S_INIT) init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
        end
    end

    // Read tracking and response FIFO pointers / occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= fire && !req_we;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents only reach rsp_data once counted valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= ram_q;
    end

endmodule

// File: tb/tb_ram_port_master.sv
// Scoreboard bench for ram_port_master with a behavioural RAM,
// a reference memory model and a decoupled response monitor.
module tb_ram_port_master;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int RD = 4;
    localparam logic [DW-1:0] IV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
    logic          ram_we, init_done;

    logic          req_ready0, rsp_valid0, ram_we0, init_done0;
    logic [DW-1:0] rsp_data0, ram_data0;
    logic [AW-1:0] ram_addr0;
    logic          req_valid0 = 1'b0;
    logic          req_we0 = 1'b0;
    logic          rsp_ready0 = 1'b1;
    logic [AW-1:0] req_addr0 = '0;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] ram_q0 = '0;

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            pops = 0;
    int            streak = 0;
    int            max_streak = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          rand_rdy = 1'b0;

    ram_port_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD),
        .INIT_EN(1), .INIT_VALUE(IV)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q), .init_done(init_done)
    );

    ram_port_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(RD),
        .INIT_EN(0), .INIT_VALUE(IV)
    ) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0), .req_data(req_data0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_we(ram_we0),
        .ram_q(ram_q0), .init_done(init_done0)
    );

    always #5 clk = ~clk;

    // Write-first synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_data;
            ram_q <= ram_data;
        end else begin
            ram_q <= ram[ram_addr];
        end
    end

    // Randomised consumer back-pressure when enabled.
    always begin
        @(posedge clk);
        #2;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations on each response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            streak = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (!(rsp_valid && rsp_data === prev_data)) begin
                    bad++;
                    $display("FAIL hold: got v=%0b d=%0h want v=1 d=%0h",
                             rsp_valid, rsp_data, prev_data);
                end
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale_rsp: got d=%0h want no response",
                             rsp_data);
                end else if (rsp_ready) begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    pops++;
                    chk("rsp_data", 32'(rsp_data), 32'(e));
                end
            end
            if (rsp_valid && rsp_ready) streak++;
            else streak = 0;
            if (streak > max_streak) max_streak = streak;
            prev_stall = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic one_cycle(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output logic fired);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_data = d;
        @(negedge clk);
        fired = req_ready;
        if (fired) begin
            if (we) ref_mem[a] = d;
            else exp_q.push_back(ref_mem[a]);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        logic f;
        for (int n = 0; n < 64; n++) begin
            one_cycle(we, a, d, f);
            if (f) return;
        end
        chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 2000; n++) begin
            if (exp_q.size() == 0 && !rsp_valid) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    // Releases reset and checks the full clear sequence on both instances.
    task automatic release_and_check_init();
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            logic [3:0] ia;
            ia = i[3:0];
            @(negedge clk);
            chk("init_cycle", 32'({ram_we, ram_addr, ram_data,
                                   init_done, req_ready}),
                32'({1'b1, ia, IV, 1'b0, 1'b0}));
            if (i == 0)
                chk("noinit_pre", 32'({init_done0, req_ready0, ram_we0}),
                    32'(0));
            if (i == 1)
                chk("noinit_done", 32'({init_done0, req_ready0, ram_we0}),
                    32'(3'b110));
        end
        @(negedge clk);
        chk("init_done", 32'({init_done, ram_we, req_ready}), 32'(3'b101));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = IV;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic          f;
        int            acc;
        int            p0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'({req_ready, rsp_valid, init_done,
                              ram_we, rsp_data}), 32'(0));
        chk("reset_out0", 32'({req_ready0, init_done0}), 32'(0));
        release_and_check_init();

        for (int i = 0; i < DEPTH; i++) send(1'b0, AW'(i), '0);
        drain();

        send(1'b1, 4'd5, 8'h3C);
        send(1'b0, 4'd5, 8'h00);
        @(negedge clk);
        chk("t2_lat1", 32'(rsp_valid), 32'(0));
        @(negedge clk);
        chk("t2_lat2", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'h3C}));
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < DEPTH; i++) send(1'b1, AW'(i), DW'($urandom));
        max_streak = 0;
        for (int i = 0; i < DEPTH; i++) begin
            one_cycle(1'b0, AW'(15 - i), '0, f);
            chk("t3_ready", 32'(f), 32'(1));
        end
        drain();
        chk("t3_streak", 32'(max_streak), 32'(DEPTH));

        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            a = AW'($urandom);
            one_cycle(1'b0, a, '0, f);
            if (f) acc++;
        end
        chk("t4_accepted", 32'(acc), 32'(RD));
        @(negedge clk);
        chk("t4_full", 32'(req_ready), 32'(0));
        @(posedge clk);
        #1;
        p0 = pops;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_still_full", 32'(req_ready), 32'(0));
        @(negedge clk);
        chk("t4_ready_back", 32'(req_ready), 32'(1));
        @(posedge clk);
        #1;
        drain();
        chk("t4_pops", 32'(pops - p0), 32'(RD));

        rsp_ready = 1'b0;
        send(1'b0, 4'd1, '0);
        send(1'b0, 4'd2, '0);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_async", 32'({rsp_valid, req_ready, ram_we, init_done}),
            32'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        release_and_check_init();
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i * 5), '0);
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            we = ($urandom_range(0, 2) == 0);
            a = AW'($urandom);
            d = DW'($urandom);
            send(we, a, d);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        chk("final_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
